msu_data_fetch: RTL and testbench

MSU_DATA_FETCH -- requirements
Module: msu_data_fetch

---
 rtl/msu_pkg.sv | 12 +
 rtl/msu_byte_fifo.sv | 60 ++++++
 rtl/msu_data_fetch.sv | 120 ++++++++++++
 tb/tb_msu_data_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msu_pkg.sv
// Shared types and constants for the MSU-1 data stream prefetcher.
package msu_pkg;

  localparam int MSU_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STALE = 2'd2
  } msu_state_e;

endpackage

// File: rtl/msu_byte_fifo.sv
// Prefetch byte FIFO: accepts a little-endian word (one or both bytes) per cycle,
// releases one byte per pop, with same-cycle flush and occupancy/free outputs.
module msu_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          push_lo,
  input  logic          push_hi,
  input  logic [15:0]   din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, hi_ptr;
  logic [CW-1:0] count_reg, push_n;
  logic [7:0]    entry_q [DEPTH];
  logic          wr_lo, wr_hi, pop_ok;

  assign wr_lo  = push_lo && !flush;
  assign wr_hi  = push_hi && !flush;
  assign pop_ok = pop && !flush && (count_reg != '0);
  // High byte lands behind the low byte when both are written together.
  assign hi_ptr = wr_lo ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
  assign push_n = CW'(wr_lo) + CW'(wr_hi);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [7:0] byte_reg;
    always_ff @(posedge CLK) begin
      if (wr_lo && wr_ptr_reg == AW'(gi)) begin
        byte_reg <= din[7:0];
      end else if (wr_hi && hi_ptr == AW'(gi)) begin
        byte_reg <= din[15:8];
      end
    end
    assign entry_q[gi] = byte_reg;
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_n);
      rd_ptr_reg <= rd_ptr_reg + AW'(pop_ok);
      count_reg  <= count_reg + push_n - CW'(pop_ok);
    end
  end

  assign head  = (count_reg == '0) ? 8'h00 : entry_q[rd_ptr_reg];
  assign count = count_reg;
  assign free  = CW'(DEPTH) - count_reg;

endmodule

// File: rtl/msu_data_fetch.sv
// MSU-1 data port prefetcher: streams bytes from word-wide memory into a small FIFO
// that the SNES drains one byte per $2001 read.
module msu_data_fetch
  import msu_pkg::*;
#(
  parameter int FIFO_DEPTH = MSU_FIFO_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        seek,
  input  logic [31:0] seek_addr,
  input  logic        req,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        underrun,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  msu_state_e    state_reg, state_next;
  logic [31:0]   fetch_addr_reg, mem_addr_reg;
  logic          skip_low_reg, armed_reg, busy_reg, underrun_reg;
  logic          fetch_start, ack_take, push_lo, push_hi, pop;
  logic [CW-1:0] fifo_count, fifo_free;

  assign pop = req && !seek;

  msu_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .flush   (seek),
    .push_lo (push_lo),
    .push_hi (push_hi),
    .din     (mem_data),
    .pop     (pop),
    .head    (data_out),
    .count   (fifo_count),
    .free    (fifo_free)
  );

  // A seek in IDLE holds off the next request one cycle so it uses the new address.
  always_comb begin
    state_next  = state_reg;
    fetch_start = 1'b0;
    ack_take    = 1'b0;
    push_lo     = 1'b0;
    push_hi     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (armed_reg && !seek && fifo_free >= CW'(2)) begin
          state_next  = ST_REQ;
          fetch_start = 1'b1;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_next = ST_IDLE;
          if (!seek) begin
            ack_take = 1'b1;
            push_hi  = 1'b1;
            push_lo  = !skip_low_reg;
          end
        end else if (seek) begin
          state_next = ST_STALE;
        end
      end
      ST_STALE: begin
        if (mem_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      fetch_addr_reg <= '0;
      mem_addr_reg   <= '0;
      skip_low_reg   <= 1'b0;
      armed_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (fetch_start) begin
        mem_addr_reg <= fetch_addr_reg;
      end
      if (seek) begin
        fetch_addr_reg <= {seek_addr[31:1], 1'b0};
        skip_low_reg   <= seek_addr[0];
        armed_reg      <= 1'b1;
        busy_reg       <= 1'b1;
        underrun_reg   <= 1'b0;
      end else begin
        if (ack_take) begin
          fetch_addr_reg <= fetch_addr_reg + 32'd2;
          skip_low_reg   <= 1'b0;
        end
        if (busy_reg && fifo_count != '0) begin
          busy_reg <= 1'b0;
        end
        if (req && fifo_count == '0) begin
          underrun_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_req  = (state_reg != ST_IDLE);
  assign mem_addr = mem_addr_reg;
  assign busy     = busy_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_msu_data_fetch.sv
// Directed bench for msu_data_fetch: seek table plus hand-written stall/stale/reset sequences.
module tb_msu_data_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        seek;
  logic [31:0] seek_addr;
  logic        req;
  logic [7:0]  data_out;
  logic        busy;
  logic        underrun;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  logic [31:0] fetch_q[$];

  always #5 CLK = ~CLK;

  msu_data_fetch #(.FIFO_DEPTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .seek      (seek),
    .seek_addr (seek_addr),
    .req       (req),
    .data_out  (data_out),
    .busy      (busy),
    .underrun  (underrun),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
  );

  // Memory image: a few fixed words, elsewhere every byte equals its address low byte.
  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    case (a)
      32'h100: return 16'hBBAA;
      32'h102: return 16'hDDCC;
      32'h200: return 16'h2211;
      32'h202: return 16'h4433;
      default: return {lo + 8'd1, lo};
    endcase
  endfunction

  // Memory responder: acks ack_delay cycles after a request is first seen.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    mem_data = 16'h0;
    forever begin
      @(negedge CLK);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          mem_data = mem_word(mem_addr);
          fetch_q.push_back(mem_addr);
          $display("mem ack addr=0x%08h data=0x%04h", mem_addr, mem_data);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_seek(input logic [31:0] a, input logic with_req);
    $display("seek addr=0x%08h req=%0b", a, with_req);
    fetch_q.delete();
    seek      = 1'b1;
    seek_addr = a;
    req       = with_req;
    @(negedge CLK);
    seek = 1'b0;
    req  = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    $display("pop %s data_out=0x%02h", name, data_out);
    check(name, {24'h0, data_out}, {24'h0, exp});
    req = 1'b1;
    @(negedge CLK);
    req = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int max);
    for (int i = 0; i < max && busy; i++) @(negedge CLK);
    check(name, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_req_low(input string name, input int max);
    for (int i = 0; i < max && mem_req; i++) @(negedge CLK);
    check(name, {31'h0, mem_req}, 32'h0);
  endtask

  task automatic wait_req_high(input string name, input int max);
    for (int i = 0; i < max && !mem_req; i++) @(negedge CLK);
    check(name, {31'h0, mem_req}, 32'h1);
  endtask

  typedef struct packed {
    logic [31:0]      addr;
    logic [3:0][7:0]  b;     // b[0] is the first byte read
    logic [31:0]      f0;
    logic [31:0]      f1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic seen;
    logic bad;

    vecs[0] = '{32'h0000_0100, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 32'h0000_0100, 32'h0000_0102};
    vecs[1] = '{32'h0000_0201, {8'h04, 8'h44, 8'h33, 8'h22}, 32'h0000_0200, 32'h0000_0202};
    vecs[2] = '{32'hFFFF_FFFE, {8'h01, 8'h00, 8'hFF, 8'hFE}, 32'hFFFF_FFFE, 32'h0000_0000};
    vecs[3] = '{32'h0000_0033, {8'h36, 8'h35, 8'h34, 8'h33}, 32'h0000_0032, 32'h0000_0034};
    vecs[4] = '{32'h0000_0010, {8'h13, 8'h12, 8'h11, 8'h10}, 32'h0000_0010, 32'h0000_0012};

    RST = 1'b1; seek = 1'b0; seek_addr = 32'h0; req = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_data_out", {24'h0, data_out}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_underrun", {31'h0, underrun}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);

    // Not armed yet: no memory traffic at all.
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (mem_req) seen = 1'b1;
    end
    check("unarmed_no_req", {31'h0, seen}, 32'h0);

    // Underrun on empty FIFO, cleared by the next seek.
    req = 1'b1;
    @(negedge CLK);
    req = 1'b0;
    check("underrun_set", {31'h0, underrun}, 32'h1);
    check("underrun_data_out", {24'h0, data_out}, 32'h0);
    do_seek(32'h100, 1'b0);
    check("underrun_cleared", {31'h0, underrun}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      wait_req_low($sformatf("v%0d_idle", i), 50);
      do_seek(vecs[i].addr, 1'b0);
      check($sformatf("v%0d_busy_set", i), {31'h0, busy}, 32'h1);
      check($sformatf("v%0d_flushed", i), {24'h0, data_out}, 32'h0);
      wait_busy_low($sformatf("v%0d_busy_clr", i), 50);
      repeat (10) @(negedge CLK);
      for (int k = 0; k < 4; k++) pop_check($sformatf("v%0d_byte%0d", i, k), vecs[i].b[k]);
      check($sformatf("v%0d_busy_stays", i), {31'h0, busy}, 32'h0);
      if (fetch_q.size() >= 2) begin
        check($sformatf("v%0d_fetch0", i), fetch_q[0], vecs[i].f0);
        check($sformatf("v%0d_fetch1", i), fetch_q[1], vecs[i].f1);
      end else begin
        check($sformatf("v%0d_fetch_cnt", i), 32'(fetch_q.size()), 32'd2);
      end
    end

    // Fill without popping: exactly 8 word fetches, then the fetcher stalls.
    wait_req_low("fill_idle", 50);
    do_seek(32'h10, 1'b0);
    repeat (60) @(negedge CLK);
    seen = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (mem_req) seen = 1'b1;
    end
    check("full_no_req", {31'h0, seen}, 32'h0);
    check("full_fetch_cnt", 32'(fetch_q.size()), 32'd8);
    for (int k = 0; k < 16; k++) pop_check($sformatf("full_byte%0d", k), 8'h10 + 8'(k));

    // Seek with coincident req, twice (second time with FIFO empty): seek wins.
    repeat (5) @(negedge CLK);
    wait_req_low("seekreq_idle", 50);
    do_seek(32'h300, 1'b1);
    check("seekreq_flushed", {24'h0, data_out}, 32'h0);
    do_seek(32'h300, 1'b1);
    check("seekreq_no_underrun", {31'h0, underrun}, 32'h0);
    check("seekreq_busy", {31'h0, busy}, 32'h1);

    // Seek while a slow request is outstanding: old request held, its data dropped.
    wait_req_low("stale_idle", 50);
    ack_delay = 20;
    do_seek(32'h150, 1'b0);
    repeat (4) @(negedge CLK);
    check("stale_req_up", {31'h0, mem_req}, 32'h1);
    check("stale_addr_old", mem_addr, 32'h150);
    $display("seek addr=0x00000500 during request");
    seek = 1'b1; seek_addr = 32'h500;
    @(negedge CLK);
    seek = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60 && fetch_q.size() == 0; i++) begin
      @(negedge CLK);
      if (!mem_req || mem_addr !== 32'h150) bad = 1'b1;
    end
    check("stale_held", {31'h0, bad}, 32'h0);
    check("stale_ack_cnt", 32'(fetch_q.size()), 32'd1);
    @(negedge CLK);
    check("stale_discard_busy", {31'h0, busy}, 32'h1);
    check("stale_discard_data", {24'h0, data_out}, 32'h0);
    wait_req_high("stale_next_req", 10);
    check("stale_next_addr", mem_addr, 32'h500);
    wait_busy_low("stale_busy_clr", 80);
    pop_check("stale_byte0", 8'h00);
    pop_check("stale_byte1", 8'h01);

    // Reset in the middle of a request drops it and disarms the fetcher.
    wait_req_high("rst_mid_req", 40);
    RST = 1'b1;
    @(negedge CLK);
    check("rstmid_mem_req", {31'h0, mem_req}, 32'h0);
    check("rstmid_mem_addr", mem_addr, 32'h0);
    check("rstmid_busy", {31'h0, busy}, 32'h0);
    check("rstmid_data_out", {24'h0, data_out}, 32'h0);
    RST = 1'b0;
    ack_delay = 0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (mem_req) seen = 1'b1;
    end
    check("rstmid_unarmed", {31'h0, seen}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
